ir_cmd_periph: RTL and testbench
================================

IR_CMD_PERIPH -- requirements
Module: ir_cmd_periph

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h90: base of 4-register bus window (BASE_ADDR..BASE_ADDR+3).
REQ-002 SHALL have parameter CARRIER_HALF, default 1250: carrier half-period in CLK cycles; one carrier period P = 2*CARRIER_HALF clocks.
REQ-003 SHALL have parameter START_LEN, default 192: start mark length in carrier periods.
REQ-004 SHALL have parameter GAP_LEN, default 25: inter-field space length in carrier periods.
REQ-005 SHALL have parameter SEL_LEN, default {8'd24,8'd34,8'd22,8'd47}: four packed 8-bit car-select mark lengths; SEL=n uses byte n.
REQ-006 SHALL have parameter ASSERT_LEN, default 47: mark length, in carrier periods, for a control bit of 1.
REQ-007 SHALL have parameter DEASSERT_LEN, default 22: mark length, in carrier periods, for a control bit of 0.
REQ-008 SHALL have parameter PERIOD_CLKS, default 10_000_000: periodic packet interval in clocks.
REQ-009 SHALL have port CLK  input  1  the only clock; all logic updates on its rising edge.
REQ-010 SHALL have port RESET  input  1  synchronous, active-low reset.
REQ-011 SHALL have port BUS_DATA  inout  8  shared data bus.
REQ-012 SHALL have port BUS_ADDR  input  8  bus address.
REQ-013 SHALL have port BUS_WE  input  1  1 = write cycle, 0 = read cycle.
REQ-014 SHALL have port IR_OUT  output  1  registered, carrier-modulated IR LED drive.

Function
REQ-015 SHALL implement this register map: +0 CTRL[3:0] (R/W); +1 SEL[1:0] (R/W); +2 CFG[0] = periodic enable (R/W); +3 write of any value = TRIGGER, read = STATUS {busy, pending, 2'b00, pkt_cnt[3:0]}.
REQ-016 SHALL update a register only on a CLK edge with BUS_WE=1 and a matching BUS_ADDR; unused bits SHALL read 0.
REQ-017 SHALL drive BUS_DATA combinationally from current register contents while BUS_WE=0 and BUS_ADDR is in the window, and SHALL hold it high-Z otherwise.
REQ-018 SHALL raise a packet request on a TRIGGER write, or when the period counter equals PERIOD_CLKS-1 while CFG[0]=1.
REQ-019 SHALL run the period counter from 0 to PERIOD_CLKS-1 and wrap, and SHALL hold it at 0 while CFG[0]=0.
REQ-020 SHALL treat simultaneous TRIGGER and period events as one request.
REQ-021 SHALL leave IDLE on the edge that registers a request when idle (busy=1); a request arriving while busy SHALL set pending=1, with at most one pending request (further ones dropped).
REQ-022 SHALL, on leaving IDLE, snapshot CTRL and SEL into shadow registers; bus writes during a packet SHALL NOT affect that packet.
REQ-023 SHALL step the FSM through IDLE -> START(mark START_LEN) -> GAP0(space GAP_LEN) -> SEL(mark SEL_LEN[SEL]) -> for i = 3 down to 0 {BGAP(space GAP_LEN), BIT(mark ASSERT_LEN if CTRL[i] else DEASSERT_LEN)} -> TAIL(space GAP_LEN) -> IDLE.
REQ-024 SHALL make each phase last exactly length*P clocks, with no gap clocks between phases.
REQ-025 SHALL, during a mark, restart the carrier at phase entry: IR_OUT=1 for CARRIER_HALF clocks, then 0 for CARRIER_HALF, repeating.
REQ-026 SHALL hold IR_OUT=0 during spaces and IDLE; because IR_OUT is registered, it SHALL lag the FSM phase by exactly 1 clock.
REQ-027 SHALL, on TAIL completion, increment pkt_cnt (4-bit, 15 wraps to 0) and clear busy; if pending=1, it SHALL clear pending and enter START on the same edge (busy stays 1).

Reset
REQ-028 SHALL, on a CLK edge with RESET=0 (including mid-packet), set CTRL=0, SEL=0, CFG=1, pkt_cnt=0, busy=0, pending=0, period counter=0, FSM=IDLE, IR_OUT=0, overriding any bus write on that edge.
REQ-029 SHALL NOT drive BUS_DATA during reset unless a read is addressed to the window.

Verification
REQ-030 SHALL be verified with bench parameters CARRIER_HALF=1, START_LEN=4, GAP_LEN=2, SEL_LEN={8'd4,8'd3,8'd2,8'd1}, ASSERT_LEN=3, DEASSERT_LEN=1, PERIOD_CLKS=200 (so P=2).
REQ-031 SHALL pass this case: after reset, read +2 returns 8'h01, read +3 returns 8'h00, IR_OUT=0, and an out-of-window read leaves BUS_DATA = Z.
REQ-032 SHALL pass this case: write CFG=0, SEL=2, CTRL=4'b1010, then TRIGGER -> IR_OUT shows mark/space runs of 8,4,6,4,6,4,2,4,6,4,2,4 clocks (marks toggle 1,0,...), STATUS then reads 8'h01.
REQ-033 SHALL pass this case: write CTRL=4'b1111 mid-packet -> the current packet is unchanged; the next TRIGGER sends four 6-clock bit marks.
REQ-034 SHALL pass this case: three TRIGGERs while busy -> STATUS reads 8'hC0 or higher; exactly two packets are sent back-to-back with no IDLE clock between them; pkt_cnt=2.
REQ-035 SHALL pass this case: CFG=1 -> START entered every 200 clocks; after 16 packets pkt_cnt reads 0.
REQ-036 SHALL pass this case: RESET=0 for 1 clock mid-START -> IR_OUT=0 and busy=0 on the next edge, registers at defaults, and no packet until a new request.

Source files
------------

// File: rtl/ir_cmd_periph.sv
// rtl/ir_cmd_periph.sv - bus-programmed IR remote command transmitter with periodic resend
module ir_cmd_periph #(
    parameter logic [7:0]  BASE_ADDR    = 8'h90,
    parameter int          CARRIER_HALF = 1250,
    parameter int          START_LEN    = 192,
    parameter int          GAP_LEN      = 25,
    parameter logic [31:0] SEL_LEN      = {8'd24, 8'd34, 8'd22, 8'd47},
    parameter int          ASSERT_LEN   = 47,
    parameter int          DEASSERT_LEN = 22,
    parameter int          PERIOD_CLKS  = 10_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic       IR_OUT
);

    localparam int CAR_P = 2 * CARRIER_HALF;
    localparam int CW    = (CAR_P > 2) ? $clog2(CAR_P) : 1;
    localparam int PW    = (PERIOD_CLKS > 2) ? $clog2(PERIOD_CLKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_GAP0, S_SEL, S_BGAP, S_BIT, S_TAIL
    } state_t;

    state_t        state, state_next;
    logic [3:0]    ctrl, sh_ctrl, pkt_cnt;
    logic [1:0]    sel, sh_sel, bit_idx;
    logic          cfg, pending, busy;
    logic [PW-1:0] period_cnt;
    logic [CW-1:0] car_cnt;
    logic [15:0]   len_cnt, phase_len;
    logic [7:0]    offset, rd_data;
    logic          in_win, wr_hit, trigger, period_evt, req;
    logic          car_last, phase_done, tail_done, restart, load, ir_next;
    logic          unused_bus_bits;

    assign offset     = BUS_ADDR - BASE_ADDR;
    assign in_win     = (offset < 8'd4);
    assign wr_hit     = BUS_WE && in_win;
    assign trigger    = wr_hit && (offset[1:0] == 2'd3);
    assign period_evt = cfg && (period_cnt == PW'(PERIOD_CLKS - 1));
    assign req        = trigger || period_evt;
    assign busy       = (state != S_IDLE);
    assign unused_bus_bits = ^BUS_DATA[7:4];

    always_comb begin
        rd_data = 8'h00;
        case (offset[1:0])
            2'd0:    rd_data = {4'b0000, ctrl};
            2'd1:    rd_data = {6'b000000, sel};
            2'd2:    rd_data = {7'b0000000, cfg};
            default: rd_data = {busy, pending, 2'b00, pkt_cnt};
        endcase
    end

    assign BUS_DATA = (!BUS_WE && in_win) ? rd_data : 8'hzz;

    // Length of the current phase in carrier periods, from the snapshot taken at packet start
    always_comb begin
        phase_len = 16'd1;
        case (state)
            S_START:                 phase_len = 16'(START_LEN);
            S_GAP0, S_BGAP, S_TAIL:  phase_len = 16'(GAP_LEN);
            S_SEL:                   phase_len = {8'd0, SEL_LEN[{sh_sel, 3'b000} +: 8]};
            S_BIT:                   phase_len = sh_ctrl[bit_idx] ? 16'(ASSERT_LEN) : 16'(DEASSERT_LEN);
            default:                 phase_len = 16'd1;
        endcase
    end

    assign car_last   = (car_cnt == CW'(CAR_P - 1));
    assign phase_done = busy && car_last && (len_cnt == phase_len - 16'd1);
    assign tail_done  = (state == S_TAIL) && phase_done;
    assign restart    = tail_done && (pending || req);
    assign load       = ((state == S_IDLE) && req) || restart;

    always_comb begin
        state_next = state;
        ir_next    = 1'b0;
        case (state)
            S_IDLE:  if (req) state_next = S_START;
            S_START: if (phase_done) state_next = S_GAP0;
            S_GAP0:  if (phase_done) state_next = S_SEL;
            S_SEL:   if (phase_done) state_next = S_BGAP;
            S_BGAP:  if (phase_done) state_next = S_BIT;
            S_BIT:   if (phase_done) state_next = (bit_idx == 2'd0) ? S_TAIL : S_BGAP;
            S_TAIL:  if (phase_done) state_next = restart ? S_START : S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if ((state == S_START) || (state == S_SEL) || (state == S_BIT))
            ir_next = (car_cnt < CW'(CARRIER_HALF));
    end

    always_ff @(posedge CLK) begin
        if (!RESET) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            ctrl       <= 4'd0;
            sel        <= 2'd0;
            cfg        <= 1'b1;
            pkt_cnt    <= 4'd0;
            pending    <= 1'b0;
            period_cnt <= '0;
            car_cnt    <= '0;
            len_cnt    <= 16'd0;
            bit_idx    <= 2'd0;
            sh_ctrl    <= 4'd0;
            sh_sel     <= 2'd0;
            IR_OUT     <= 1'b0;
        end else begin
            if (wr_hit) begin
                case (offset[1:0])
                    2'd0:    ctrl <= BUS_DATA[3:0];
                    2'd1:    sel  <= BUS_DATA[1:0];
                    2'd2:    cfg  <= BUS_DATA[0];
                    default: ;
                endcase
            end

            if (!cfg || period_evt) period_cnt <= '0;
            else                    period_cnt <= period_cnt + 1'b1;

            // Carrier restarts at every phase boundary so each mark begins high
            if (phase_done || !busy) begin
                car_cnt <= '0;
                len_cnt <= 16'd0;
            end else if (car_last) begin
                car_cnt <= '0;
                len_cnt <= len_cnt + 16'd1;
            end else begin
                car_cnt <= car_cnt + 1'b1;
            end

            if ((state == S_SEL) && phase_done)      bit_idx <= 2'd3;
            else if ((state == S_BIT) && phase_done) bit_idx <= bit_idx - 2'd1;

            if (load) begin
                sh_ctrl <= ctrl;
                sh_sel  <= sel;
            end

            if (restart)          pending <= pending && req;
            else if (busy && req) pending <= 1'b1;

            if (tail_done) pkt_cnt <= pkt_cnt + 4'd1;

            IR_OUT <= ir_next;
        end
    end

endmodule

// File: tb/tb_ir_cmd_periph.sv
// tb/tb_ir_cmd_periph.sv - self-checking bench for ir_cmd_periph against a waveform model
module tb_ir_cmd_periph;

    localparam logic [7:0] BASE = 8'h90;
    localparam int HALF   = 1;
    localparam int P      = 2;
    localparam int START  = 4;
    localparam int GAP    = 2;
    localparam int ASRT   = 3;
    localparam int DEASRT = 1;
    localparam int PERIOD = 200;
    localparam int LOGN   = 16384;

    typedef struct {
        bit         we;
        logic [7:0] addr;
        logic [7:0] data;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic       drv_en;
    logic [7:0] drv_val;
    wire  [7:0] bus_data;
    wire        ir_out;

    int   sel_tab [4] = '{1, 2, 3, 4};
    int   cyc = 0;
    bit   ir_log [LOGN];
    bit   exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   cnt_m = 0;
    vec_t vt [17];

    assign bus_data = drv_en ? drv_val : 8'hzz;

    ir_cmd_periph #(
        .BASE_ADDR(BASE), .CARRIER_HALF(HALF), .START_LEN(START), .GAP_LEN(GAP),
        .SEL_LEN({8'd4, 8'd3, 8'd2, 8'd1}), .ASSERT_LEN(ASRT), .DEASSERT_LEN(DEASRT),
        .PERIOD_CLKS(PERIOD)
    ) dut (
        .CLK(clk), .RESET(reset_n), .BUS_DATA(bus_data), .BUS_ADDR(bus_addr),
        .BUS_WE(bus_we), .IR_OUT(ir_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < LOGN) ir_log[cyc] <= ir_out;

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded its time budget at clock %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus_addr = addr; bus_we = 1'b1; drv_en = 1'b1; drv_val = data;
        @(negedge clk);
        bus_we = 1'b0; drv_en = 1'b0; bus_addr = 8'h00;
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [7:0] v);
        @(negedge clk);
        bus_addr = addr; bus_we = 1'b0; drv_en = 1'b0;
        #1 v = bus_data;
    endtask

    task automatic read_check(input string name, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] v;
        bus_read(addr, v);
        check8(name, v, exp);
    endtask

    // A phase of len carrier periods; marks start high for HALF clocks, then alternate
    function automatic void add_phase(input bit mark, input int len);
        for (int j = 0; j < len * P; j++)
            exp_q.push_back(mark && ((j % P) < HALF));
    endfunction

    function automatic void add_packet(input logic [3:0] c, input logic [1:0] s);
        add_phase(1'b1, START);
        add_phase(1'b0, GAP);
        add_phase(1'b1, sel_tab[s]);
        for (int i = 3; i >= 0; i--) begin
            add_phase(1'b0, GAP);
            add_phase(1'b1, c[i] ? ASRT : DEASRT);
        end
        add_phase(1'b0, GAP);
    endfunction

    // IR sample k after the request edge t0 is the model's clock k (one-clock register lag)
    task automatic check_wave(input string name, input int t0);
        int bad = 0;
        int first = -1;
        while (cyc < t0 + exp_q.size() + 2) @(negedge clk);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (ir_log[t0 + 1 + k] != exp_q[k]) begin
                if (first < 0) first = k;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d of %0d clocks differ, first at clock %0d got %0b expected %0b",
                     name, bad, exp_q.size(), first, ir_log[t0 + 1 + first], exp_q[first]);
        end
    endtask

    function automatic logic [7:0] status_m(input bit b, input bit p);
        return {b, p, 2'b00, 4'(cnt_m)};
    endfunction

    initial begin
        logic [7:0] v;
        logic [3:0] c, c2;
        logic [1:0] s, s2;
        int t0, tr, d, bad;

        reset_n = 1'b0; bus_we = 1'b0; drv_en = 1'b0; drv_val = 8'h00; bus_addr = 8'h00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        #1 check8("ir_reset", {7'b0, ir_out}, 8'h00);
        bus_read(8'h94, v);
        checks++;
        if (!(v === 8'hzz || v === 8'h00)) begin
            errors++;
            $display("FAIL bus_z_above: got %h expected zz", v);
        end
        bus_read(8'h8F, v);
        checks++;
        if (!(v === 8'hzz || v === 8'h00)) begin
            errors++;
            $display("FAIL bus_z_below: got %h expected zz", v);
        end

        vt[0]  = '{1'b0, BASE + 8'd2, 8'h01};
        vt[1]  = '{1'b0, BASE + 8'd3, 8'h00};
        vt[2]  = '{1'b0, BASE + 8'd0, 8'h00};
        vt[3]  = '{1'b0, BASE + 8'd1, 8'h00};
        vt[4]  = '{1'b1, BASE + 8'd2, 8'hFE};
        vt[5]  = '{1'b0, BASE + 8'd2, 8'h00};
        vt[6]  = '{1'b1, BASE + 8'd0, 8'hFF};
        vt[7]  = '{1'b0, BASE + 8'd0, 8'h0F};
        vt[8]  = '{1'b1, BASE + 8'd1, 8'hFF};
        vt[9]  = '{1'b0, BASE + 8'd1, 8'h03};
        vt[10] = '{1'b1, BASE + 8'd1, 8'h02};
        vt[11] = '{1'b1, BASE + 8'd0, 8'h0A};
        vt[12] = '{1'b1, 8'h94,       8'hFF};
        vt[13] = '{1'b1, 8'h8F,       8'hFF};
        vt[14] = '{1'b0, BASE + 8'd0, 8'h0A};
        vt[15] = '{1'b0, BASE + 8'd1, 8'h02};
        vt[16] = '{1'b0, BASE + 8'd3, 8'h00};
        for (int i = 0; i < 17; i++) begin
            if (vt[i].we) bus_write(vt[i].addr, vt[i].data);
            else          read_check($sformatf("vec%0d", i), vt[i].addr, vt[i].data);
        end

        // Single packet CTRL=1010 SEL=2
        bus_write(BASE + 8'd3, 8'h00);
        t0 = cyc;
        exp_q.delete();
        add_packet(4'b1010, 2'd2);
        check_wave("pkt_1010_sel2", t0);
        cnt_m++;
        read_check("status_after_pkt", BASE + 8'd3, status_m(1'b0, 1'b0));

        // CTRL written mid-packet must not disturb the packet in flight
        bus_write(BASE + 8'd3, 8'h00);
        t0 = cyc;
        bus_write(BASE + 8'd0, 8'h0F);
        exp_q.delete();
        add_packet(4'b1010, 2'd2);
        check_wave("shadow_ctrl", t0);
        cnt_m++;
        read_check("ctrl_after_midwrite", BASE + 8'd0, 8'h0F);
        bus_write(BASE + 8'd3, 8'h00);
        t0 = cyc;
        exp_q.delete();
        add_packet(4'b1111, 2'd2);
        check_wave("pkt_1111", t0);
        cnt_m++;

        for (int it = 0; it < 16; it++) begin
            c = 4'($urandom_range(0, 15));
            s = 2'($urandom_range(0, 3));
            c2 = 4'($urandom_range(0, 15));
            s2 = 2'($urandom_range(0, 3));
            d = $urandom_range(0, 20);
            bus_write(BASE + 8'd0, {4'hA, c});
            bus_write(BASE + 8'd1, {6'b101010, s});
            bus_write(BASE + 8'd3, 8'($urandom));
            t0 = cyc;
            repeat (d) @(negedge clk);
            bus_write(BASE + 8'd0, {4'h5, c2});
            bus_write(BASE + 8'd1, {6'b010101, s2});
            exp_q.delete();
            add_packet(c, s);
            check_wave($sformatf("rand_pkt%0d", it), t0);
            cnt_m++;
            read_check("rand_ctrl", BASE + 8'd0, {4'h0, c2});
            read_check("rand_sel", BASE + 8'd1, {6'h00, s2});
            read_check("rand_status", BASE + 8'd3, status_m(1'b0, 1'b0));
        end

        // Extra triggers while busy collapse into one back-to-back packet
        bus_write(BASE + 8'd0, 8'h05);
        bus_write(BASE + 8'd1, 8'h00);
        bus_write(BASE + 8'd3, 8'h00);
        t0 = cyc;
        repeat (3) bus_write(BASE + 8'd3, 8'h00);
        read_check("status_pending", BASE + 8'd3, status_m(1'b1, 1'b1));
        exp_q.delete();
        add_packet(4'b0101, 2'd0);
        add_packet(4'b0101, 2'd0);
        check_wave("back_to_back", t0);
        cnt_m += 2;
        read_check("status_after_pair", BASE + 8'd3, status_m(1'b0, 1'b0));

        // Reset mid-START, with a CTRL write on the same edge
        bus_write(BASE + 8'd1, 8'h03);
        bus_write(BASE + 8'd3, 8'h00);
        repeat (3) @(negedge clk);
        reset_n = 1'b0; bus_addr = BASE; bus_we = 1'b1; drv_en = 1'b1; drv_val = 8'hFF;
        @(negedge clk);
        reset_n = 1'b1; bus_we = 1'b0; drv_en = 1'b0; bus_addr = 8'h00;
        tr = cyc;
        cnt_m = 0;
        #1 check8("ir_after_reset", {7'b0, ir_out}, 8'h00);
        read_check("status_after_reset", BASE + 8'd3, 8'h00);
        read_check("ctrl_after_reset", BASE + 8'd0, 8'h00);
        read_check("sel_after_reset", BASE + 8'd1, 8'h00);
        read_check("cfg_after_reset", BASE + 8'd2, 8'h01);
        while (cyc < tr + 170) @(negedge clk);
        bad = 0;
        for (int k = tr; k < tr + 169; k++) if (ir_log[k]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_after_reset: got %0d high clocks expected 0", bad);
        end
        bus_write(BASE + 8'd2, 8'h00);

        // Periodic mode from reset: START every PERIOD clocks, 16 packets wrap pkt_cnt
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tr = cyc;
        cnt_m = 0;
        exp_q.delete();
        repeat (PERIOD) exp_q.push_back(1'b0);
        for (int n = 0; n < 16; n++) begin
            t0 = exp_q.size();
            add_packet(4'b0000, 2'd0);
            if (n < 15) while (exp_q.size() < t0 + PERIOD) exp_q.push_back(1'b0);
        end
        repeat (20) exp_q.push_back(1'b0);
        check_wave("periodic16", tr);
        cnt_m = (cnt_m + 16) % 16;
        read_check("status_after_16", BASE + 8'd3, status_m(1'b0, 1'b0));
        bus_write(BASE + 8'd2, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
